// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch stage: address out, combinational read data back.
interface fetch_unit_if #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 16
);
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_data;

  modport master (output imem_addr, input  imem_data);
  modport slave  (input  imem_addr, output imem_data);
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, next-PC select, F/D pipeline buffer, and the
// control unit's registered sequencing state and interrupt request latch.
module fetch_unit #(
  parameter int unsigned       PC_W         = 32,
  parameter int unsigned       INST_W       = 16,
  parameter logic [PC_W-1:0]   RESET_VECTOR = '0,
  parameter logic [INST_W-1:0] NOP_WORD     = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_enable,
  input  logic              f_d_buffer_enable,
  input  logic              flush,
  input  logic [1:0]        jump_sel,
  input  logic [PC_W-1:0]   jump_target,
  input  logic [PC_W-1:0]   int_vector,
  input  logic [PC_W-1:0]   ret_addr,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  input  logic              interrupt,
  input  logic              int_ack,
  input  logic              call_dec,
  input  logic [1:0]        inter_state_after,
  input  logic [2:0]        ret_state_after,
  input  logic [2:0]        reti_state_after,
  fetch_unit_if.master      imem,
  output logic [INST_W-1:0] fd_inst,
  output logic [INST_W-1:0] fd_imm,
  output logic [PC_W-1:0]   fd_pc_next,
  output logic              int_req,
  output logic [1:0]        inter_state_before,
  output logic [2:0]        ret_state_before,
  output logic [2:0]        reti_state_before,
  output logic              inst_before_call
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc_c;
  logic [PC_W-1:0] pc_next_c;

  assign imem.imem_addr = pc;
  assign pc_inc_c       = pc + PC_W'(1);

  // Resolved branch from execute outranks any stall or redirect from decode.
  always_comb begin
    pc_next_c = pc;
    if (branch_taken) begin
      pc_next_c = branch_target;
    end else if (pc_enable) begin
      unique case (jump_sel)
        2'b00:   pc_next_c = pc_inc_c;
        2'b01:   pc_next_c = jump_target;
        2'b10:   pc_next_c = int_vector;
        default: pc_next_c = ret_addr;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_VECTOR;
    else        pc <= pc_next_c;
  end

  // Flush bubbles the buffer but keeps the fetched word as the LDM immediate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fd_inst    <= NOP_WORD;
      fd_imm     <= '0;
      fd_pc_next <= '0;
    end else if (branch_taken) begin
      fd_inst    <= NOP_WORD;
    end else if (flush) begin
      fd_inst    <= NOP_WORD;
      fd_imm     <= imem.imem_data;
    end else if (f_d_buffer_enable) begin
      fd_inst    <= imem.imem_data;
      fd_pc_next <= pc_inc_c;
    end
  end

  // A new request arriving with an ack must survive, so set wins over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_req            <= 1'b0;
      inter_state_before <= '0;
      ret_state_before   <= '0;
      reti_state_before  <= '0;
      inst_before_call   <= 1'b0;
    end else begin
      int_req            <= interrupt | (int_req & ~int_ack);
      inter_state_before <= inter_state_after;
      ret_state_before   <= ret_state_after;
      reti_state_before  <= reti_state_after;
      inst_before_call   <= call_dec;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage and F/D pipeline register, directly upstream of the decode-stage control unit.
- Holds the PC, selects the next PC, presents the PC to instruction memory, and latches the fetched word into the F/D buffer.
- Also registers the control unit's multi-cycle sequencing state (interrupt/RET/RETI/CALL) and latches the external interrupt request.
- Obeys pc_enable, f_d_buffer_enable, flush and jump_sel exactly as the control unit drives them.

Parameters:
PC_W, 32, PC and all address widths
INST_W, 16, instruction word width
RESET_VECTOR, 0, PC value after reset
NOP_WORD, 0, word inserted into fd_inst on flush/reset (opcode 000000)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc_enable  in  1  from control unit; 0 holds PC
f_d_buffer_enable  in  1  from control unit; 0 holds F/D buffer
flush  in  1  from control unit; bubble next F/D contents
jump_sel  in  2  00 PC+1, 01 jump_target, 10 int_vector, 11 ret_addr
jump_target  in  PC_W  JMP target from decode register read
int_vector  in  PC_W  interrupt handler address
ret_addr  in  PC_W  popped return address from memory stage
branch_taken  in  1  execute-stage conditional branch resolved taken
branch_target  in  PC_W  execute-stage branch target
imem_data  in  INST_W  instruction memory read data, combinational on imem_addr
interrupt  in  1  external interrupt pulse
int_ack  in  1  control unit accepted interrupt (left NO_INTERRUPT)
call_dec  in  1  decoded opcode is CALL this cycle
inter_state_after  in  2  control-unit next interrupt state
ret_state_after  in  3  control-unit next RET state
reti_state_after  in  3  control-unit next RETI state
imem_addr  out  PC_W  equals pc register
fd_inst  out  INST_W  F/D buffered instruction
fd_imm  out  INST_W  immediate word captured on flush
fd_pc_next  out  PC_W  PC+1 of buffered instruction
int_req  out  1  latched interrupt request to control unit
inter_state_before  out  2  registered interrupt state
ret_state_before  out  3  registered RET state
reti_state_before  out  3  registered RETI state
inst_before_call  out  1  registered call_dec

Behaviour:
- Reset (async, rst_n=0): pc=RESET_VECTOR; fd_inst=NOP_WORD; fd_imm=0; fd_pc_next=0; int_req=0; all *_state_before=0; inst_before_call=0. Release takes effect on the first rising edge after deassertion.
- imem_addr = pc at all times (combinational). Fetch latency: 1 cycle into the F/D buffer.
- Next-PC priority at each edge:
  - branch_taken=1 → branch_target, regardless of pc_enable (older instruction wins).
  - else pc_enable=0 → hold.
  - else jump_sel: 00 → pc+1; 01 → jump_target; 10 → int_vector; 11 → ret_addr.
- PC arithmetic: pc+1 wraps modulo 2^PC_W, with no overflow flag.
- F/D buffer priority at each edge:
  - branch_taken=1 → fd_inst=NOP_WORD; fd_imm and fd_pc_next hold.
  - else flush=1 → fd_inst=NOP_WORD, fd_imm=imem_data (LDM immediate capture). flush overrides f_d_buffer_enable=0.
  - else f_d_buffer_enable=1 → fd_inst=imem_data, fd_pc_next=pc+1.
  - else hold all.
- Sequencing state: inter/ret/reti_state_before load the corresponding *_after every edge, unconditionally. Stalls and flushes do not affect them. inst_before_call loads call_dec every edge.
- Interrupt latch: int_req sets on interrupt=1 and clears on int_ack=1. If both occur in the same cycle, int_req stays 1 (new request not lost). Holding interrupt high keeps int_req high.
- Reset mid-sequence (e.g. ret_state_before=011) returns all states to 0 immediately; no partial pops are retained.
- No combinational path from any input to any registered output except imem_addr=pc.

Test Plan:
- Reset then 4 edges, imem returns 0x0401,0x0502,... → pc 0,1,2,3,4; fd_inst follows one cycle behind; fd_pc_next=pc of the instruction +1.
- pc=10, jump_sel=01, jump_target=0x200, flush=1, imem_data=0xABCD → pc=0x200, fd_inst=0, fd_imm=0xABCD.
- pc=5, pc_enable=0, f_d_buffer_enable=0, branch_taken=1, branch_target=0x40 → pc=0x40, fd_inst=0.
- pc=0xFFFFFFFF, jump_sel=00 → pc=0 next edge.
- interrupt pulse, then interrupt and int_ack together on a later cycle → int_req=1 throughout; int_ack alone next cycle → int_req=0.
- Drive ret_state_after 1,2,3,4,0 on successive edges → ret_state_before lags by one edge; assert rst_n=0 mid-sequence → all state outputs 0 immediately, without waiting for a clock edge.
